// File: rtl/truth_table_checker.sv
// truth_table_checker: exhaustive truth-table tester for a small combinational gate.
// Drives every input vector in binary order and holds each one for DWELL cycles.
// On the last dwell cycle it samples z_in and compares it against EXPECTED.
// It reports pass/fail, the mismatch count and the first failing vector.
module truth_table_checker #(
   parameter int                     N_IN     = 3,
   parameter int                     DWELL    = 20,
   parameter logic [(1<<N_IN)-1:0]   EXPECTED = 8'hFE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              z_in,
   output logic [N_IN-1:0]   x,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_count,
   output logic              fail_valid,
   output logic [N_IN-1:0]   first_fail_vec
);

   localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_APPLY = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [TW-1:0]   T_LAST = TW'(DWELL - 1);
   localparam logic [N_IN-1:0] V_LAST = '1;

   logic [1:0]    state;
   logic [TW-1:0] timer;
   logic          sample;
   logic          mismatch;
   logic [N_IN:0] err_next;

   // Sample strobe on the last dwell cycle, and the error count including this sample.
   // x doubles as the vector counter: it equals the current vector throughout APPLY.
   always_comb begin
      sample   = (state == S_APPLY) && (timer == T_LAST);
      mismatch = sample && (z_in != EXPECTED[x]);
      err_next = err_count + {{N_IN{1'b0}}, mismatch};
   end

   // Sequencer: start/restart, vector stepping, result capture and completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         timer          <= '0;
         x              <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         fail_valid     <= 1'b0;
         first_fail_vec <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state          <= S_APPLY;
                  timer          <= '0;
                  x              <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  fail_valid     <= 1'b0;
                  first_fail_vec <= '0;
               end
            end
            S_APPLY: begin
               if (sample) begin
                  err_count <= err_next;
                  if (mismatch && !fail_valid) begin
                     first_fail_vec <= x;
                     fail_valid     <= 1'b1;
                  end
                  if (x == V_LAST) begin
                     // pass uses err_next so the final vector's result is included.
                     state <= S_DONE;
                     x     <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == '0);
                  end else begin
                     x     <= x + 1'b1;
                     timer <= '0;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: lane 0 uses DWELL=20, lane 1 uses DWELL=1 (both OR3).
// Each lane's simulated gate is a truth table tt_l; runs are queued with their expectations.
module tb_truth_table_checker;

   localparam logic [7:0] EXP = 8'hFE;

   typedef struct {
      int         lane;
      int         t;        // cycle in which start was sampled
      logic [7:0] tt;       // truth table of the simulated gate for this run
      int         exp_err;
      int         exp_first;
      int         exp_fv;
      int         exp_pass;
   } run_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_l [2];
   logic [7:0] tt_l    [2];
   logic       z_l     [2];
   logic [2:0] x_l     [2];
   logic       busy_l  [2];
   logic       done_l  [2];
   logic       pass_l  [2];
   logic [3:0] err_l   [2];
   logic       fv_l    [2];
   logic [2:0] ffv_l   [2];

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   run_t q[$];

   always #5 clk = ~clk;

   // Cycle counter, read at negedges.
   always @(posedge clk) cyc <= cyc + 1;

   assign z_l[0] = tt_l[0][x_l[0]];
   assign z_l[1] = tt_l[1][x_l[1]];

   truth_table_checker #(.N_IN(3), .DWELL(20), .EXPECTED(8'hFE)) dut (
      .clk(clk), .rst(rst), .start(start_l[0]), .z_in(z_l[0]),
      .x(x_l[0]), .busy(busy_l[0]), .done(done_l[0]), .pass(pass_l[0]),
      .err_count(err_l[0]), .fail_valid(fv_l[0]), .first_fail_vec(ffv_l[0])
   );

   truth_table_checker #(.N_IN(3), .DWELL(1), .EXPECTED(8'hFE)) dut1 (
      .clk(clk), .rst(rst), .start(start_l[1]), .z_in(z_l[1]),
      .x(x_l[1]), .busy(busy_l[1]), .done(done_l[1]), .pass(pass_l[1]),
      .err_count(err_l[1]), .fail_valid(fv_l[1]), .first_fail_vec(ffv_l[1])
   );

   function automatic int dwell_of(input int lane);
      return (lane == 0) ? 20 : 1;
   endfunction

   // Reference: number of vectors k < n whose gate output differs from EXP.
   function automatic int mism_upto(input logic [7:0] tt, input int n);
      logic [7:0] e;
      int cnt;
      e = EXP;
      cnt = 0;
      for (int k = 0; k < n; k++) if (tt[k] !== e[k]) cnt++;
      return cnt;
   endfunction

   function automatic int first_mism(input logic [7:0] tt);
      logic [7:0] e;
      e = EXP;
      for (int k = 0; k < 8; k++) if (tt[k] !== e[k]) return k;
      return 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset(input int lane);
      check("rst_x",    int'(x_l[lane]),    0);
      check("rst_busy", int'(busy_l[lane]), 0);
      check("rst_done", int'(done_l[lane]), 0);
      check("rst_pass", int'(pass_l[lane]), 0);
      check("rst_err",  int'(err_l[lane]),  0);
      check("rst_fv",   int'(fv_l[lane]),   0);
      check("rst_ffv",  int'(ffv_l[lane]),  0);
   endtask

   task automatic push_run(input int lane, input logic [7:0] tt);
      run_t r;
      int e;
      r.lane = lane;
      r.t    = cyc;
      r.tt   = tt;
      e = mism_upto(tt, 8);
      r.exp_err   = e;
      r.exp_fv    = (e != 0) ? 1 : 0;
      r.exp_first = first_mism(tt);
      r.exp_pass  = (e == 0) ? 1 : 0;
      q.push_back(r);
   endtask

   // Called at a negedge: start is high for this cycle and sampled at the next posedge.
   task automatic start_run(input int lane, input logic [7:0] tt, input bit hold);
      tt_l[lane]    = tt;
      start_l[lane] = 1'b1;
      push_run(lane, tt);
      @(negedge clk);
      if (!hold) start_l[lane] = 1'b0;
   endtask

   task automatic wait_done(input int lane);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (done_l[lane]) seen = 1'b1;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout lane %0d: got done=0 expected done=1", lane);
      end
   endtask

   // Monitor: per-cycle progress checks for the active run, final compare on done rise.
   logic pd [2] = '{1'b0, 1'b0};
   run_t m_e;
   int   m_el;
   int   m_d;
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         m_d = dwell_of(i);
         if (!rst && q.size() > 0 && q[0].lane == i && cyc > q[0].t) begin
            m_e  = q[0];
            m_el = cyc - m_e.t - 1;
            if (m_el < 8 * m_d) begin
               check("run_busy", int'(busy_l[i]), 1);
               check("run_done", int'(done_l[i]), 0);
               check("run_x",    int'(x_l[i]),    m_el / m_d);
               check("run_err",  int'(err_l[i]),  mism_upto(m_e.tt, m_el / m_d));
            end
         end
         if (done_l[i] && !pd[i]) begin
            if (q.size() == 0 || q[0].lane != i) begin
               check("unexpected_done", 1, 0);
            end else begin
               m_e = q.pop_front();
               check("done_cycle", cyc,               m_e.t + 1 + 8 * m_d);
               check("done_busy",  int'(busy_l[i]),   0);
               check("done_x",     int'(x_l[i]),      0);
               check("done_pass",  int'(pass_l[i]),   m_e.exp_pass);
               check("done_err",   int'(err_l[i]),    m_e.exp_err);
               check("done_fv",    int'(fv_l[i]),     m_e.exp_fv);
               if (m_e.exp_fv != 0) check("done_ffv", int'(ffv_l[i]), m_e.exp_first);
            end
         end
         pd[i] = done_l[i];
      end
   end

   initial begin
      bit hit;
      start_l[0] = 1'b0;
      start_l[1] = 1'b0;
      tt_l[0]    = EXP;
      tt_l[1]    = EXP;
      rst        = 1'b1;
      repeat (3) @(negedge clk);
      check_reset(0);
      check_reset(1);
      rst = 1'b0;
      @(negedge clk);

      // Ideal, stuck-at-0 and stuck-at-1 gates.
      start_run(0, EXP, 1'b0);   wait_done(0);
      start_run(0, 8'h00, 1'b0); wait_done(0);
      start_run(0, 8'hFF, 1'b0); wait_done(0);

      // Randomized faulty gates.
      for (int r = 0; r < 3; r++) begin
         start_run(0, 8'($urandom_range(0, 255)), 1'b0);
         wait_done(0);
      end

      // Mid-run reset while x==4, with start also high in the reset cycle.
      start_run(0, 8'h00, 1'b0);
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         if (x_l[0] == 3'd4) hit = 1'b1;
         else @(negedge clk);
      end
      check("reach_x4", int'(hit), 1);
      rst        = 1'b1;
      start_l[0] = 1'b1;
      q.delete();
      @(negedge clk);
      check_reset(0);
      rst        = 1'b0;
      start_l[0] = 1'b0;
      @(negedge clk);
      check("rst_override_busy", int'(busy_l[0]), 0);
      start_run(0, EXP, 1'b0);   wait_done(0);

      // start held through a stuck-at-0 run, then restart from DONE with an ideal gate.
      start_run(0, 8'h00, 1'b1);
      wait_done(0);
      tt_l[0] = EXP;
      push_run(0, EXP);
      @(negedge clk);
      start_l[0] = 1'b0;
      wait_done(0);

      // DWELL=1 lane: ideal, then random.
      start_run(1, EXP, 1'b0);   wait_done(1);
      start_run(1, 8'($urandom_range(0, 255)), 1'b0); wait_done(1);
      start_run(1, 8'h00, 1'b0); wait_done(1);

      repeat (2) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      n_fail++;
      $display("FAIL watchdog: got no completion expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
